// File: rtl/comp3_if.sv
// ---------------------------------------------------------------------------
// comp3_if
// Groups the bit-level operand and flag signals of the 3-bit comparator.
//   a0..a2 : operand A bits, a2 = MSB   (driven by master)
//   b0..b2 : operand B bits, b2 = MSB   (driven by master)
//   l/e/g  : registered A<B / A==B / A>B flags (driven by slave)
// ---------------------------------------------------------------------------
interface comp3_if;
  logic a0;
  logic a1;
  logic a2;
  logic b0;
  logic b1;
  logic b2;
  logic l;
  logic e;
  logic g;

  modport master (
    output a0, a1, a2, b0, b1, b2,
    input  l, e, g
  );

  modport slave (
    input  a0, a1, a2, b0, b1, b2,
    output l, e, g
  );
endinterface

// File: rtl/comp3_reg.sv
// ---------------------------------------------------------------------------
// comp3_reg
// 3-bit unsigned magnitude comparator with registered less/equal/greater
// flags. One 1-bit compare cell per bit, an MSB-first priority cascade, then
// a single output register (1-cycle latency, no enable).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears l/e/g immediately
//   bus   : comp3_if.slave -- operands a0..a2 / b0..b2 in, flags l/e/g out
// ---------------------------------------------------------------------------
module comp3_reg (
  input  logic    clk,
  input  logic    rst_n,
  comp3_if.slave  bus
);

  logic [2:0] a_p0;
  logic [2:0] b_p0;
  logic [2:0] gt_p0;
  logic [2:0] lt_p0;
  logic [2:0] eq_p0;
  logic       l_p0;
  logic       e_p0;
  logic       g_p0;
  logic       l_p1;
  logic       e_p1;
  logic       g_p1;

  assign a_p0 = {bus.a2, bus.a1, bus.a0};
  assign b_p0 = {bus.b2, bus.b1, bus.b0};

  // ---- stage p0: per-bit compare cells ----
  for (genvar i = 0; i < 3; i++) begin : g_cell
    assign gt_p0[i] =  a_p0[i] & ~b_p0[i];
    assign lt_p0[i] = ~a_p0[i] &  b_p0[i];
    assign eq_p0[i] = ~(a_p0[i] ^ b_p0[i]);
  end

  // MSB-first cascade: a lower bit only decides when all higher bits match.
  assign g_p0 = gt_p0[2] | (eq_p0[2] & gt_p0[1]) | (eq_p0[2] & eq_p0[1] & gt_p0[0]);
  assign l_p0 = lt_p0[2] | (eq_p0[2] & lt_p0[1]) | (eq_p0[2] & eq_p0[1] & lt_p0[0]);
  assign e_p0 = eq_p0[2] & eq_p0[1] & eq_p0[0];

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_p1 <= 1'b0;
      e_p1 <= 1'b0;
      g_p1 <= 1'b0;
    end else begin
      l_p1 <= l_p0;
      e_p1 <= e_p0;
      g_p1 <= g_p0;
    end
  end

  assign bus.l = l_p1;
  assign bus.e = e_p1;
  assign bus.g = g_p1;

endmodule

// File: tb/tb_comp3_reg.sv
// ---------------------------------------------------------------------------
// tb_comp3_reg
// Directed bench for comp3_reg: reset behaviour, hand-computed compare
// vectors, back-to-back operand changes, exhaustive sweep and async clear.
// Flags are handled as a 3-bit vector {l,e,g}.
// ---------------------------------------------------------------------------
module tb_comp3_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  comp3_if u_if ();

  comp3_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] LEG_L = 3'b100;
  localparam logic [2:0] LEG_E = 3'b010;
  localparam logic [2:0] LEG_G = 3'b001;
  localparam logic [2:0] LEG_0 = 3'b000;

  function automatic logic [2:0] flags();
    return {u_if.l, u_if.e, u_if.g};
  endfunction

  // Reference: ordinary integer comparison.
  function automatic logic [2:0] model(input int a, input int b);
    return {a < b, a == b, a > b};
  endfunction

  task automatic set_ab(input logic [2:0] a, input logic [2:0] b);
    u_if.a0 = a[0]; u_if.a1 = a[1]; u_if.a2 = a[2];
    u_if.b0 = b[0]; u_if.b1 = b[1]; u_if.b2 = b[2];
  endtask

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed leg=%b expected leg=%b", tag, got, exp);
    end
  endtask

  // Apply operands at the falling edge, check the flags 1 time unit after
  // the following rising edge.
  task automatic step(input string tag, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] exp);
    @(negedge clk);
    set_ab(a, b);
    @(posedge clk);
    #1;
    chk(tag, flags(), exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_ab(3'd5, 3'd2);

    // Reset held: edges must not load the compare.
    #1;
    chk("reset_initial", flags(), LEG_0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_held", flags(), LEG_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_pre_edge", flags(), LEG_0);
    @(posedge clk);
    #1;
    chk("first_edge_5_2", flags(), LEG_G);

    // Equal cases.
    step("eq_0_0", 3'd0, 3'd0, LEG_E);
    step("eq_3_3", 3'd3, 3'd3, LEG_E);
    step("eq_7_7", 3'd7, 3'd7, LEG_E);

    // Less-than cases.
    step("lt_1_3", 3'd1, 3'd3, LEG_L);
    step("lt_2_5", 3'd2, 3'd5, LEG_L);
    step("lt_1_7", 3'd1, 3'd7, LEG_L);

    // Greater-than cases, MSB dominating lower bits.
    step("gt_7_5", 3'd7, 3'd5, LEG_G);
    step("gt_5_1", 3'd5, 3'd1, LEG_G);
    step("gt_4_3", 3'd4, 3'd3, LEG_G);

    // Back-to-back: each new operand pair must leave the old flags standing
    // until the next edge, then show up exactly one cycle later.
    step("b2b_3_3", 3'd3, 3'd3, LEG_E);
    @(negedge clk);
    set_ab(3'd1, 3'd3);
    #1;
    chk("b2b_hold_e", flags(), LEG_E);
    @(posedge clk);
    #1;
    chk("b2b_1_3", flags(), LEG_L);
    @(negedge clk);
    set_ab(3'd7, 3'd5);
    #1;
    chk("b2b_hold_l", flags(), LEG_L);
    @(posedge clk);
    #1;
    chk("b2b_7_5", flags(), LEG_G);

    // Exhaustive sweep against the integer model plus one-hot invariant.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        step($sformatf("sweep_%0d_%0d", a, b), 3'(a), 3'(b), model(a, b));
        checks++;
        assert ($onehot(flags())) else begin
          errors++;
          $error("FAIL onehot_%0d_%0d: observed leg=%b expected one-hot", a, b, flags());
        end
      end
    end

    // Asynchronous clear between edges, in-flight compare discarded.
    step("pre_async_6_2", 3'd6, 3'd2, LEG_G);
    @(negedge clk);
    set_ab(3'd1, 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", flags(), LEG_0);
    @(posedge clk);
    #1;
    chk("async_clear_held", flags(), LEG_0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async_release_pre_edge", flags(), LEG_0);
    @(posedge clk);
    #1;
    chk("async_first_edge_1_6", flags(), LEG_L);
    step("after_async_6_6", 3'd6, 3'd6, LEG_E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
